// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the single data-memory port: one transaction in flight,
// read responses routed to their issuer, and a lock that keeps the grant for AMO sequences.
module dmem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SIZE_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s0_req_valid,
  output logic              s0_req_ready,
  input  logic              s0_req_wen,
  input  logic [ADDR_W-1:0] s0_req_addr,
  input  logic [DATA_W-1:0] s0_req_wdata,
  input  logic [SIZE_W-1:0] s0_req_wmask,
  input  logic              s0_req_lock,
  output logic              s0_resp_valid,
  output logic [DATA_W-1:0] s0_resp_rdata,
  input  logic              s1_req_valid,
  output logic              s1_req_ready,
  input  logic              s1_req_wen,
  input  logic [ADDR_W-1:0] s1_req_addr,
  input  logic [DATA_W-1:0] s1_req_wdata,
  input  logic [SIZE_W-1:0] s1_req_wmask,
  input  logic              s1_req_lock,
  output logic              s1_resp_valid,
  output logic [DATA_W-1:0] s1_resp_rdata,
  output logic              m_req_valid,
  input  logic              m_req_ready,
  output logic              m_req_wen,
  output logic [ADDR_W-1:0] m_req_addr,
  output logic [DATA_W-1:0] m_req_wdata,
  output logic [SIZE_W-1:0] m_req_wmask,
  input  logic              m_resp_valid,
  input  logic [DATA_W-1:0] m_resp_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic {IDLE, WAIT_RESP} state_t;

  state_t state, state_nxt;
  logic   last_grant, hold, lock_valid, lock_owner, resp_owner, owner_q;
  logic   grant, sel_valid, sel_wen, sel_lock, accept, idle;

  assign idle = (state == IDLE);

  // Stalled request keeps its grant first, then the lock, then round-robin.
  always_comb begin
    grant = owner_q;
    if (hold)                             grant = owner_q;
    else if (lock_valid)                  grant = lock_owner;
    else if (s0_req_valid && s1_req_valid) grant = ~last_grant;
    else if (s1_req_valid)                grant = 1'b1;
    else if (s0_req_valid)                grant = 1'b0;
  end

  assign sel_valid   = grant ? s1_req_valid : s0_req_valid;
  assign sel_wen     = grant ? s1_req_wen   : s0_req_wen;
  assign sel_lock    = grant ? s1_req_lock  : s0_req_lock;
  assign m_req_wen   = sel_wen;
  assign m_req_addr  = grant ? s1_req_addr  : s0_req_addr;
  assign m_req_wdata = grant ? s1_req_wdata : s0_req_wdata;
  assign m_req_wmask = grant ? s1_req_wmask : s0_req_wmask;
  assign m_req_valid = sel_valid && idle;
  assign accept      = m_req_valid && m_req_ready;

  assign s0_req_ready = m_req_ready && !grant && idle;
  assign s1_req_ready = m_req_ready &&  grant && idle;

  assign s0_resp_valid = !idle && m_resp_valid && !resp_owner;
  assign s1_resp_valid = !idle && m_resp_valid &&  resp_owner;
  assign s0_resp_rdata = m_resp_rdata;
  assign s1_resp_rdata = m_resp_rdata;

  assign busy  = !idle;
  assign owner = (hold || lock_valid) ? owner_q : grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept && !sel_wen) state_nxt = WAIT_RESP;
      WAIT_RESP: if (m_resp_valid)       state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      hold       <= 1'b0;
      lock_valid <= 1'b0;
      lock_owner <= 1'b0;
      resp_owner <= 1'b0;
      owner_q    <= 1'b0;
    end else if (idle) begin
      owner_q <= grant;
      hold    <= m_req_valid && !m_req_ready;
      if (accept) begin
        last_grant <= grant;
        if (!sel_wen) resp_owner <= grant;
        // Only an unlocked request from the lock holder releases the lock.
        if (sel_lock) begin
          lock_valid <= 1'b1;
          lock_owner <= grant;
        end else if (grant == lock_owner) begin
          lock_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed sequences with accept/response scoreboards.
module tb_dmem_port_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SIZE_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s0_req_valid = 0, s0_req_wen = 0, s0_req_lock = 0;
  logic [ADDR_W-1:0] s0_req_addr = '0;
  logic [DATA_W-1:0] s0_req_wdata = '0;
  logic [SIZE_W-1:0] s0_req_wmask = '0;
  logic s1_req_valid = 0, s1_req_wen = 0, s1_req_lock = 0;
  logic [ADDR_W-1:0] s1_req_addr = '0;
  logic [DATA_W-1:0] s1_req_wdata = '0;
  logic [SIZE_W-1:0] s1_req_wmask = '0;
  logic m_req_ready = 0, m_resp_valid = 0;
  logic [DATA_W-1:0] m_resp_rdata = '0;
  logic s0_req_ready, s1_req_ready, s0_resp_valid, s1_resp_valid;
  logic [DATA_W-1:0] s0_resp_rdata, s1_resp_rdata;
  logic m_req_valid, m_req_wen, busy, owner;
  logic [ADDR_W-1:0] m_req_addr;
  logic [DATA_W-1:0] m_req_wdata;
  logic [SIZE_W-1:0] m_req_wmask;

  int total = 0;
  int bad = 0;
  logic [ADDR_W:0] acc_q[$];
  logic [DATA_W:0] resp_q[$];

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_req_valid(s0_req_valid), .s0_req_ready(s0_req_ready), .s0_req_wen(s0_req_wen),
    .s0_req_addr(s0_req_addr), .s0_req_wdata(s0_req_wdata), .s0_req_wmask(s0_req_wmask),
    .s0_req_lock(s0_req_lock), .s0_resp_valid(s0_resp_valid), .s0_resp_rdata(s0_resp_rdata),
    .s1_req_valid(s1_req_valid), .s1_req_ready(s1_req_ready), .s1_req_wen(s1_req_wen),
    .s1_req_addr(s1_req_addr), .s1_req_wdata(s1_req_wdata), .s1_req_wmask(s1_req_wmask),
    .s1_req_lock(s1_req_lock), .s1_resp_valid(s1_resp_valid), .s1_resp_rdata(s1_resp_rdata),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_wen(m_req_wen),
    .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata), .m_req_wmask(m_req_wmask),
    .m_resp_valid(m_resp_valid), .m_resp_rdata(m_resp_rdata),
    .busy(busy), .owner(owner)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic wen, input logic [ADDR_W-1:0] a, input logic lk);
    s0_req_valid = v; s0_req_wen = wen; s0_req_addr = a; s0_req_lock = lk;
    s0_req_wdata = a ^ 32'h5A5A_0000; s0_req_wmask = 2'd2;
  endtask

  task automatic drive1(input logic v, input logic wen, input logic [ADDR_W-1:0] a, input logic lk);
    s1_req_valid = v; s1_req_wen = wen; s1_req_addr = a; s1_req_lock = lk;
    s1_req_wdata = a ^ 32'hA5A5_0000; s1_req_wmask = 2'd1;
  endtask

  task automatic do_reset();
    adv();
    rst_n = 1'b0;
    drive0(0, 0, 0, 0); drive1(0, 0, 0, 0);
    m_req_ready = 0; m_resp_valid = 0;
    adv();
    adv();
    rst_n = 1'b1;
  endtask

  // Accept and response monitor; sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_req_valid && m_req_ready) begin
        if (acc_q.size() == 0) chk("acc_unexpected", 1, 0);
        else begin
          logic [ADDR_W:0] e;
          e = acc_q.pop_front();
          chk("acc_owner", owner, e[ADDR_W]);
          chk("acc_addr", m_req_addr, e[ADDR_W-1:0]);
          chk("acc_ready", owner ? s1_req_ready : s0_req_ready, 1);
          chk("acc_wdata", m_req_wdata,
              owner ? (m_req_addr ^ 32'hA5A5_0000) : (m_req_addr ^ 32'h5A5A_0000));
        end
      end
      if (s0_resp_valid && s1_resp_valid) chk("resp_both", 1, 0);
      else if (s0_resp_valid || s1_resp_valid) begin
        if (resp_q.size() == 0) chk("resp_unexpected", 1, 0);
        else begin
          logic [DATA_W:0] r;
          r = resp_q.pop_front();
          chk("resp_owner", s1_resp_valid, r[DATA_W]);
          chk("resp_data", s1_resp_valid ? s1_resp_rdata : s0_resp_rdata, r[DATA_W-1:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    adv(); adv();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_m_valid", m_req_valid, 0);
    chk("rst_resp", {s0_resp_valid, s1_resp_valid}, 0);
    rst_n = 1'b1;

    // Single s0 load, response two cycles after accept
    adv();
    drive0(1, 0, 32'h100, 0); m_req_ready = 1; acc_q.push_back({1'b0, 32'h100});
    @(negedge clk);
    chk("t1_m_valid", m_req_valid, 1);
    adv();
    drive0(0, 0, 0, 0);
    @(negedge clk);
    chk("t1_busy_a", busy, 1);
    chk("t1_no_ready", s0_req_ready, 0);
    adv();
    m_resp_valid = 1; m_resp_rdata = 32'hDEADBEEF; resp_q.push_back({1'b0, 32'hDEADBEEF});
    @(negedge clk);
    chk("t1_busy_b", busy, 1);
    chk("t1_s0_resp", s0_resp_valid, 1);
    chk("t1_s1_resp", s1_resp_valid, 0);
    adv();
    m_resp_valid = 0;
    @(negedge clk);
    chk("t1_busy_end", busy, 0);
    chk("t1_resp_q", resp_q.size(), 0);

    // Continuous stores from both: strict alternation
    do_reset();
    drive0(1, 1, 32'hA0, 0); drive1(1, 1, 32'hB0, 0); m_req_ready = 1;
    for (int i = 0; i < 4; i++) begin
      acc_q.push_back((i % 2 == 0) ? {1'b0, 32'hA0} : {1'b1, 32'hB0});
      @(negedge clk);
      chk("t2_accept", m_req_valid && m_req_ready, 1);
      chk("t2_owner", owner, (i % 2 == 0) ? 1'b0 : 1'b1);
      adv();
    end
    drive0(0, 0, 0, 0); drive1(0, 0, 0, 0);
    @(negedge clk);
    chk("t2_acc_q", acc_q.size(), 0);

    // Stalled s1 load keeps the grant while s0 arrives
    adv();
    drive1(1, 0, 32'h300, 0); m_req_ready = 0;
    @(negedge clk);
    chk("t3_owner_c1", owner, 1);
    adv();
    drive0(1, 0, 32'h304, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t3_owner_hold", owner, 1);
      chk("t3_addr_hold", m_req_addr, 32'h300);
      chk("t3_s0_ready", s0_req_ready, 0);
      adv();
    end
    m_req_ready = 1; acc_q.push_back({1'b1, 32'h300});
    @(negedge clk);
    chk("t3_s1_ready", s1_req_ready, 1);
    adv();
    drive1(0, 0, 0, 0);
    m_resp_valid = 1; m_resp_rdata = 32'h1111; resp_q.push_back({1'b1, 32'h1111});
    @(negedge clk);
    chk("t3_s0_ready_busy", s0_req_ready, 0);
    adv();
    m_resp_valid = 0; acc_q.push_back({1'b0, 32'h304});
    @(negedge clk);
    chk("t3_s0_served", s0_req_ready, 1);
    adv();
    drive0(0, 0, 0, 0);
    m_resp_valid = 1; m_resp_rdata = 32'h2222; resp_q.push_back({1'b0, 32'h2222});
    adv();
    m_resp_valid = 0;

    // Locked AMO sequence from s0 holds off s1
    drive0(1, 0, 32'h200, 1); acc_q.push_back({1'b0, 32'h200});
    adv();
    drive0(0, 0, 0, 0); drive1(1, 1, 32'h400, 0);
    m_resp_valid = 1; m_resp_rdata = 32'h5; resp_q.push_back({1'b0, 32'h5});
    adv();
    m_resp_valid = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t4_s1_locked_out", s1_req_ready, 0);
      chk("t4_m_valid", m_req_valid, 0);
      chk("t4_owner", owner, 0);
      adv();
    end
    drive0(1, 1, 32'h200, 0); acc_q.push_back({1'b0, 32'h200});
    @(negedge clk);
    chk("t4_s1_still_out", s1_req_ready, 0);
    chk("t4_s0_store", s0_req_ready, 1);
    adv();
    drive0(0, 0, 0, 0); acc_q.push_back({1'b1, 32'h400});
    @(negedge clk);
    chk("t4_s1_granted", s1_req_ready, 1);
    adv();
    drive1(0, 0, 0, 0);

    // Spurious response while idle
    m_resp_valid = 1; m_resp_rdata = 32'hBAD;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t5_resp", {s0_resp_valid, s1_resp_valid}, 0);
      chk("t5_busy", busy, 0);
      adv();
    end
    m_resp_valid = 0;

    // Reset while a read is outstanding
    drive0(1, 0, 32'h500, 0); acc_q.push_back({1'b0, 32'h500});
    adv();
    drive0(0, 0, 0, 0);
    @(negedge clk);
    chk("t6_busy_pre", busy, 1);
    adv();
    rst_n = 0;
    @(negedge clk);
    chk("t6_busy_rst", busy, 0);
    adv();
    rst_n = 1;
    m_resp_valid = 1; m_resp_rdata = 32'hBAD0;
    @(negedge clk);
    chk("t6_late_resp", {s0_resp_valid, s1_resp_valid}, 0);
    adv();
    m_resp_valid = 0;
    drive0(1, 0, 32'h600, 0); acc_q.push_back({1'b0, 32'h600});
    @(negedge clk);
    chk("t6_new_ready", s0_req_ready, 1);
    adv();
    drive0(0, 0, 0, 0);
    m_resp_valid = 1; m_resp_rdata = 32'h600D; resp_q.push_back({1'b0, 32'h600D});
    @(negedge clk);
    chk("t6_new_resp", s0_resp_valid, 1);
    adv();
    m_resp_valid = 0;
    @(negedge clk);
    chk("end_acc_q", acc_q.size(), 0);
    chk("end_resp_q", resp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port (DReq/DResp-style: valid/ready request, valid response) between two requesters.
- Requester 0 is the memory stage; requester 1 is a secondary master (page-table walker or debug/DMA).
- Keeps one transaction outstanding, routes each read response to the requester that issued it, and supports a lock so AMO read-modify-write sequences reach memory atomically.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, read/write data width (XLEN)
SIZE_W, 2, width of wmask/size code (MemSize encoding, passed through unchanged)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
s0_req_valid  in  1  requester 0 request valid
s0_req_ready  out  1  requester 0 request accepted this cycle
s0_req_wen  in  1  1=store, 0=load
s0_req_addr  in  ADDR_W  address
s0_req_wdata  in  DATA_W  store data
s0_req_wmask  in  SIZE_W  access size
s0_req_lock  in  1  keep grant after this request (AMO first half)
s0_resp_valid  out  1  read data valid for requester 0
s0_resp_rdata  out  DATA_W  read data
s1_req_valid, s1_req_ready, s1_req_wen, s1_req_addr, s1_req_wdata, s1_req_wmask, s1_req_lock, s1_resp_valid, s1_resp_rdata: same as s0_*, for requester 1
m_req_valid  out  1  request to memory
m_req_ready  in  1  memory accepts request
m_req_wen, m_req_addr, m_req_wdata, m_req_wmask  out  as above  muxed request fields
m_resp_valid  in  1  memory read response valid
m_resp_rdata  in  DATA_W  memory read data
busy  out  1  read outstanding (state WAIT_RESP)
owner  out  1  current grant index

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, last_grant=1, hold=0, lock_valid=0, owner=0.
  - Combinational outputs follow from these: m_req_valid=0 unless s0/s1 is valid; all s*_resp_valid=0.
- States:
  - IDLE: may issue a request.
  - WAIT_RESP: a read is outstanding; m_req_valid=0 and both s*_req_ready=0.
- Grant selection in IDLE, evaluated in this order:
  - If hold=1, grant stays with owner. Hold is set when m_req_valid=1 and m_req_ready=0, so the request stays stable until accepted.
  - Else if lock_valid=1, only lock_owner is eligible; the other requester gets ready=0 even if memory is idle.
  - Else round-robin: if both are valid, grant goes to !last_grant; if one is valid, it wins.
- Datapath:
  - m_req_* = fields of the granted requester.
  - m_req_valid = granted s*_req_valid and state==IDLE.
  - s*_req_ready = m_req_ready and granted and state==IDLE. Ready is 0 for the non-granted requester.
- On acceptance (m_req_valid and m_req_ready):
  - last_grant <= owner; hold <= 0.
  - If wen=0: state <= WAIT_RESP, resp_owner <= owner.
  - If wen=1: state stays IDLE; the store completes on acceptance and no response is routed.
  - If lock=1: lock_valid <= 1, lock_owner <= owner.
  - If lock=0 and owner==lock_owner: lock_valid <= 0.
- In WAIT_RESP, on m_resp_valid:
  - s[resp_owner]_resp_valid=1 combinationally, same cycle; rdata passes through to both s*_resp_rdata.
  - state <= IDLE. The next request issues no earlier than the following cycle.
- m_resp_valid while IDLE: dropped, never forwarded.
- Minimum latency:
  - Read: accept at cycle N, response at N+1 or later.
  - Back-to-back stores: one per cycle.
- Locked owner deasserting valid does not release the lock; only an accepted unlocked request from the owner releases it.
- Reset mid-transaction: the outstanding read is abandoned and the lock cleared. A late m_resp_valid after reset is dropped (IDLE rule).
- owner output = registered grant when hold=1 or lock_valid=1, else the combinational selection.
- busy = (state==WAIT_RESP).

Test Plan:
- s0 load addr 0x100, memory ready immediately, response 2 cycles later with 0xDEADBEEF: s0_resp_valid=1 with 0xDEADBEEF, s1_resp_valid stays 0, busy=1 for exactly 2 cycles.
- s0 and s1 both store continuously after reset, m_req_ready=1: grants alternate s0, s1, s0, s1; one accept per cycle.
- s1 load valid, m_req_ready=0 for 3 cycles, s0 becomes valid in cycle 2: grant stays s1 and m_req_addr is stable until accepted; s0 is served next.
- s0 lock load 0x200 (response 5), then s1 requests continuously, then s0 unlocked store 0x200: s1_req_ready=0 until the s0 store is accepted; s1 is granted the cycle after.
- Spurious m_resp_valid while IDLE: no s*_resp_valid pulses; state unchanged.
- rst_n pulled low while busy=1, then released, then m_resp_valid pulses: all state cleared, response dropped, new s0 load proceeds normally.
